// File: rtl/dotp_pkg.sv
// ============================================================
// dotp_pkg : shared types and helpers for the dot-product engine
// Revision: 1.0
// ============================================================
`default_nettype none

package dotp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        FINISH  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int DEF_N_ELEM = 16;
    localparam int DEF_LANES  = 2;
    localparam int N_GRP      = DEF_N_ELEM / DEF_LANES;

    // Finish-stage width: wide enough for acc+bias plus any rounding term.
    localparam int FIN_W = 128;

    function automatic logic signed [FIN_W-1:0] sat_clamp(
        input logic signed [FIN_W-1:0] value,
        input int                      width
    );
        logic signed [FIN_W-1:0] hi;
        logic signed [FIN_W-1:0] lo;
        hi             = '0;
        hi[width-1]    = 1'b1;
        hi             = hi - FIN_W'(1);
        lo             = -hi - FIN_W'(1);
        if (value > hi)      sat_clamp = hi;
        else if (value < lo) sat_clamp = lo;
        else                 sat_clamp = value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dotp_group_mac.sv
// ============================================================
// dotp_group_mac : masked signed multipliers and group reduction
// Revision: 1.0
// ============================================================
`default_nettype none

module dotp_group_mac #(
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int ACC_W  = 72,
    parameter int CNT_W  = 2
) (
    input  logic [LANES*DATA_W-1:0] i_a,
    input  logic [LANES*DATA_W-1:0] i_b,
    input  logic [LANES-1:0]        i_mask,
    output logic signed [ACC_W-1:0] o_sum,
    output logic [CNT_W-1:0]        o_pop
);

    localparam int c_prod_w = 2 * DATA_W;

    logic signed [ACC_W-1:0] w_prod [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [c_prod_w-1:0] w_full;
        assign w_full    = c_prod_w'($signed(i_a[l*DATA_W +: DATA_W]))
                         * c_prod_w'($signed(i_b[l*DATA_W +: DATA_W]));
        assign w_prod[l] = i_mask[l] ? ACC_W'(w_full) : '0;
    end

    always_comb begin
        o_sum = '0;
        o_pop = '0;
        for (int l = 0; l < LANES; l++) begin
            o_sum = o_sum + w_prod[l];
            o_pop = o_pop + CNT_W'(i_mask[l]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sparse_dot_engine.sv
// ============================================================
// sparse_dot_engine : zero-skipping signed dot-product engine
// Revision: 1.0
// ============================================================
`default_nettype none

module sparse_dot_engine
    import dotp_pkg::*;
#(
    parameter int N_ELEM = 16,
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int ACC_W  = 72,
    parameter int OUT_W  = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_valid_i,
    output logic                        start_ready_o,
    input  logic [N_ELEM*DATA_W-1:0]    a_i,
    input  logic [N_ELEM*DATA_W-1:0]    b_i,
    input  logic [DATA_W-1:0]           bias_i,
    input  logic [$clog2(ACC_W)-1:0]    shift_i,
    output logic [OUT_W-1:0]            result_o,
    output logic                        sat_o,
    output logic [$clog2(N_ELEM+1)-1:0] mac_count_o,
    output logic                        result_valid_o,
    input  logic                        result_ready_i
);

    localparam int c_n_grp    = N_ELEM / LANES;
    localparam int c_grp_w    = (c_n_grp > 1) ? $clog2(c_n_grp) : 1;
    localparam int c_cnt_w    = $clog2(N_ELEM + 1);
    localparam int c_pop_w    = $clog2(LANES + 1);
    localparam int c_sh_w     = $clog2(ACC_W);
    localparam int c_vec_w    = N_ELEM * DATA_W;
    localparam int c_grp_bits = LANES * DATA_W;

    if (N_ELEM % LANES != 0) begin : g_chk_lanes
        $error("N_ELEM must be a multiple of LANES");
    end
    if (ACC_W < 2 * DATA_W + $clog2(N_ELEM) + 1) begin : g_chk_acc
        $error("ACC_W too narrow for the worst-case sum");
    end
    if (OUT_W > ACC_W) begin : g_chk_out
        $error("OUT_W must not exceed ACC_W");
    end
    if ((ACC_W + 2 > FIN_W) || ((1 << c_sh_w) > FIN_W)) begin : g_chk_fin
        $error("ACC_W too wide for the finish stage");
    end

    state_t                     r_state;
    state_t                     w_state_next;
    logic [c_vec_w-1:0]         r_a;
    logic [c_vec_w-1:0]         r_b;
    logic signed [DATA_W-1:0]   r_bias;
    logic [c_sh_w-1:0]          r_shift;
    logic [N_ELEM-1:0]          r_mask;
    logic [c_grp_w-1:0]         r_grp;
    logic signed [ACC_W-1:0]    r_acc;
    logic [c_cnt_w-1:0]         r_mac_cnt;
    logic [OUT_W-1:0]           r_result;
    logic                       r_sat;
    logic [c_cnt_w-1:0]         r_mac_out;

    logic                       w_accept;
    logic [N_ELEM-1:0]          w_start_mask;
    logic [N_ELEM-1:0]          w_mask_rem;
    logic signed [ACC_W-1:0]    w_grp_sum;
    logic [c_pop_w-1:0]         w_grp_pop;
    logic signed [FIN_W-1:0]    w_fin;
    logic signed [FIN_W-1:0]    w_clamped;
    logic                       w_sat;

    // Lowest group holding at least one live pair; descending scan so the lowest wins.
    function automatic logic [c_grp_w-1:0] lowest_grp(input logic [N_ELEM-1:0] m);
        lowest_grp = '0;
        for (int g = c_n_grp - 1; g >= 0; g--) begin
            if (|m[g*LANES +: LANES]) lowest_grp = c_grp_w'(g);
        end
    endfunction

    assign w_accept = start_valid_i && (r_state == IDLE);

    always_comb begin
        w_start_mask = '0;
        for (int k = 0; k < N_ELEM; k++) begin
            w_start_mask[k] = (|a_i[k*DATA_W +: DATA_W]) && (|b_i[k*DATA_W +: DATA_W]);
        end
    end

    always_comb begin
        w_mask_rem = r_mask;
        w_mask_rem[r_grp*LANES +: LANES] = '0;
    end

    dotp_group_mac #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W),
        .CNT_W  (c_pop_w)
    ) u_group_mac (
        .i_a    (r_a[r_grp*c_grp_bits +: c_grp_bits]),
        .i_b    (r_b[r_grp*c_grp_bits +: c_grp_bits]),
        .i_mask (r_mask[r_grp*LANES +: LANES]),
        .o_sum  (w_grp_sum),
        .o_pop  (w_grp_pop)
    );

    // Round half up, then arithmetic shift and clamp.
    always_comb begin
        w_fin = FIN_W'(r_acc) + FIN_W'(r_bias);
        if (r_shift != '0) begin
            w_fin = w_fin + (FIN_W'(1) <<< (r_shift - c_sh_w'(1)));
            w_fin = w_fin >>> r_shift;
        end
        w_clamped = sat_clamp(w_fin, OUT_W);
        w_sat     = (w_clamped != w_fin);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = (w_start_mask == '0) ? FINISH : COMPUTE;
            COMPUTE: if (w_mask_rem == '0) w_state_next = FINISH;
            FINISH:  w_state_next = HOLD;
            HOLD:    if (result_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        start_ready_o  = 1'b0;
        result_valid_o = 1'b0;
        case (r_state)
            IDLE:    start_ready_o  = 1'b1;
            HOLD:    result_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a       <= '0;
            r_b       <= '0;
            r_bias    <= '0;
            r_shift   <= '0;
            r_mask    <= '0;
            r_grp     <= '0;
            r_acc     <= '0;
            r_mac_cnt <= '0;
            r_result  <= '0;
            r_sat     <= 1'b0;
            r_mac_out <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_a       <= a_i;
                    r_b       <= b_i;
                    r_bias    <= $signed(bias_i);
                    r_shift   <= shift_i;
                    r_mask    <= w_start_mask;
                    r_grp     <= lowest_grp(w_start_mask);
                    r_acc     <= '0;
                    r_mac_cnt <= '0;
                end
                COMPUTE: begin
                    r_acc     <= r_acc + w_grp_sum;
                    r_mac_cnt <= r_mac_cnt + c_cnt_w'(w_grp_pop);
                    r_mask    <= w_mask_rem;
                    r_grp     <= lowest_grp(w_mask_rem);
                end
                FINISH: begin
                    r_result  <= w_clamped[OUT_W-1:0];
                    r_sat     <= w_sat;
                    r_mac_out <= r_mac_cnt;
                end
                default: ;
            endcase
        end
    end

    assign result_o    = r_result;
    assign sat_o       = r_sat;
    assign mac_count_o = r_mac_out;

endmodule

`default_nettype wire
